drive_pulse_sequencer: RTL and testbench

Per-qubit drive-channel sequencer that accepts gate commands over a valid/ready handshake and sequences the polar-modulation datapath. It owns the free-running NCO phase accumulator and the virtual-Z frame register, and it walks envelope-memory addresses for each pulse. It emits the `valid_in` / `nco_phase` stream aligned with the envelope memory's phase and amplitude read data. It sits between the gate-command queue and the drive polar modulation unit.

---
 rtl/drive_seq_pkg.sv | 14 +
 rtl/nco_phase_accumulator.sv | 37 +++
 rtl/drive_pulse_sequencer.sv | 135 +++++++++++++
 tb/tb_drive_pulse_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/drive_seq_pkg.sv
// Shared definitions for the drive-channel sequencer and the polar modulation unit.
// Holds the sequencer state encoding and the default datapath widths.
package drive_seq_pkg;

  // Phase width matches the modulation unit's sin/cos LUT address width.
  localparam int unsigned DRV_PHASE_WIDTH    = 10;
  localparam int unsigned DRV_ENV_ADDR_WIDTH = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/nco_phase_accumulator.sv
// Free-running NCO phase accumulator with a loadable frequency control word.
// The accumulator keeps running in every state so that pulses stay phase-coherent.
module nco_phase_accumulator #(
  parameter int unsigned PHASE_WIDTH = 10,
  parameter int unsigned ACC_WIDTH   = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [ACC_WIDTH-1:0]   i_fcw,
  output logic [PHASE_WIDTH-1:0] o_phase
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_fcw;

  // The step taken on a load edge still uses the previous control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_fcw <= '0;
    end else begin
      if (i_load) begin
        r_fcw <= i_fcw;
      end
      if (i_clear) begin
        r_acc <= '0;
      end else begin
        r_acc <= r_acc + r_fcw;
      end
    end
  end

  assign o_phase = r_acc[ACC_WIDTH-1 -: PHASE_WIDTH];

endmodule

// File: rtl/drive_pulse_sequencer.sv
// Per-qubit drive-channel sequencer: accepts gate commands, walks envelope memory and
// issues NCO phase plus virtual-Z frame to the polar modulation unit.
module drive_pulse_sequencer
  import drive_seq_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH    = DRV_PHASE_WIDTH,
  parameter int unsigned ACC_WIDTH      = 22,
  parameter int unsigned ENV_ADDR_WIDTH = DRV_ENV_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ACC_WIDTH-1:0]      cmd_fcw,
  input  logic [PHASE_WIDTH-1:0]    cmd_phase_offset,
  input  logic                      cmd_phase_reset,
  input  logic [ENV_ADDR_WIDTH-1:0] cmd_env_base,
  input  logic [LEN_WIDTH-1:0]      cmd_env_len,
  output logic                      env_rd_en,
  output logic [ENV_ADDR_WIDTH-1:0] env_rd_addr,
  output logic                      mod_valid,
  output logic [PHASE_WIDTH-1:0]    mod_nco_phase,
  output logic                      busy,
  output logic                      done
);

  if (ACC_WIDTH < PHASE_WIDTH) begin : g_width_check
    $error("ACC_WIDTH must be at least PHASE_WIDTH");
  end

  seq_state_e                r_state;
  seq_state_e                w_state_nxt;
  logic                      w_cmd_ready;
  logic                      w_last;
  logic                      w_accept;
  logic                      w_play_load;
  logic [PHASE_WIDTH-1:0]    w_acc_phase;
  logic [PHASE_WIDTH-1:0]    w_issue_phase;

  logic [PHASE_WIDTH-1:0]    r_frame;
  logic [ENV_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]      r_cnt;
  logic                      r_mod_valid;
  logic [PHASE_WIDTH-1:0]    r_mod_phase;
  logic                      r_done;

  nco_phase_accumulator #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_nco (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_play_load),
    .i_clear (w_play_load && cmd_phase_reset),
    .i_fcw   (cmd_fcw),
    .o_phase (w_acc_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready opens in the last PLAY cycle so a following pulse starts with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_last      = 1'b0;
    w_accept    = 1'b0;
    w_play_load = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
      end
      ST_PLAY: begin
        w_last      = (r_cnt == LEN_WIDTH'(1));
        w_cmd_ready = w_last;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_accept    = cmd_valid && w_cmd_ready;
    w_play_load = w_accept && (cmd_env_len != '0);
    if (w_play_load) begin
      w_state_nxt = ST_PLAY;
    end
  end

  assign w_issue_phase = w_acc_phase + r_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame     <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_mod_valid <= 1'b0;
      r_mod_phase <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_frame <= r_frame + cmd_phase_offset;
      end
      if (w_play_load) begin
        r_addr <= cmd_env_base;
        r_cnt  <= cmd_env_len;
      end else if (r_state == ST_PLAY) begin
        r_addr <= r_addr + ENV_ADDR_WIDTH'(1);
        r_cnt  <= r_cnt - LEN_WIDTH'(1);
      end
      // Delayed one cycle to line up with the envelope memory read data.
      r_mod_valid <= (r_state == ST_PLAY);
      r_done      <= w_last;
      if (r_state == ST_PLAY) begin
        r_mod_phase <= w_issue_phase;
      end
    end
  end

  assign cmd_ready     = w_cmd_ready;
  assign env_rd_en     = (r_state == ST_PLAY);
  assign env_rd_addr   = r_addr;
  assign busy          = (r_state == ST_PLAY);
  assign mod_valid     = r_mod_valid;
  assign mod_nco_phase = r_mod_phase;
  assign done          = r_done;

endmodule

// File: tb/tb_drive_pulse_sequencer.sv
// Directed bench for drive_pulse_sequencer with hand-computed phase and address sequences.
module tb_drive_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [21:0] cmd_fcw;
  logic [9:0]  cmd_phase_offset;
  logic        cmd_phase_reset;
  logic [9:0]  cmd_env_base;
  logic [9:0]  cmd_env_len;
  logic        env_rd_en;
  logic [9:0]  env_rd_addr;
  logic        mod_valid;
  logic [9:0]  mod_nco_phase;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_addr [16];
  logic [9:0] exp_ph   [16];

  always #5 clk = ~clk;

  drive_pulse_sequencer #(
    .PHASE_WIDTH    (10),
    .ACC_WIDTH      (22),
    .ENV_ADDR_WIDTH (10),
    .LEN_WIDTH      (10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_fcw          (cmd_fcw),
    .cmd_phase_offset (cmd_phase_offset),
    .cmd_phase_reset  (cmd_phase_reset),
    .cmd_env_base     (cmd_env_base),
    .cmd_env_len      (cmd_env_len),
    .env_rd_en        (env_rd_en),
    .env_rd_addr      (env_rd_addr),
    .mod_valid        (mod_valid),
    .mod_nco_phase    (mod_nco_phase),
    .busy             (busy),
    .done             (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [21:0] fcw, input logic [9:0] off, input logic prst,
                         input logic [9:0] base, input logic [9:0] len);
    cmd_valid        = 1'b1;
    cmd_fcw          = fcw;
    cmd_phase_offset = off;
    cmd_phase_reset  = prst;
    cmd_env_base     = base;
    cmd_env_len      = len;
  endtask

  task automatic set_exp(input int idx, input logic [9:0] a, input logic [9:0] p);
    exp_addr[idx] = a;
    exp_ph[idx]   = p;
  endtask

  // Entered in the first cycle after the accepting edge.
  task automatic check_pulse(input int unsigned len);
    for (int unsigned i = 0; i < len; i++) begin
      check_eq("rd_en", env_rd_en, 1);
      check_eq("rd_addr", env_rd_addr, exp_addr[i]);
      check_eq("busy", busy, 1);
      check_eq("cmd_ready", cmd_ready, (i == len - 1) ? 1 : 0);
      if (i > 0) begin
        check_eq("mod_valid", mod_valid, 1);
        check_eq("phase", mod_nco_phase, exp_ph[i-1]);
        check_eq("done_low", done, 0);
      end
      step();
    end
    check_eq("rd_en_end", env_rd_en, 0);
    check_eq("busy_end", busy, 0);
    check_eq("mod_valid_last", mod_valid, 1);
    check_eq("phase_last", mod_nco_phase, exp_ph[len-1]);
    check_eq("done", done, 1);
    step();
    check_eq("mod_valid_after", mod_valid, 0);
    check_eq("done_after", done, 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_fcw = '0;
    cmd_phase_offset = '0;
    cmd_phase_reset = 1'b0;
    cmd_env_base = '0;
    cmd_env_len = '0;
    step();
    step();
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", env_rd_en, 0);
    check_eq("rst_rd_addr", env_rd_addr, 0);
    check_eq("rst_mod_valid", mod_valid, 0);
    check_eq("rst_phase", mod_nco_phase, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Basic play
    set_cmd(22'd4096, 10'd0, 1'b1, 10'd5, 10'd4);
    step();
    cmd_valid = 1'b0;
    set_exp(0, 10'd5, 10'd0); set_exp(1, 10'd6, 10'd1);
    set_exp(2, 10'd7, 10'd2); set_exp(3, 10'd8, 10'd3);
    check_pulse(4);

    // Virtual Z then the same play command
    set_cmd(22'd777, 10'd256, 1'b1, 10'd9, 10'd0);
    step();
    check_eq("vz_busy", busy, 0);
    check_eq("vz_rd_en", env_rd_en, 0);
    check_eq("vz_ready", cmd_ready, 1);
    set_cmd(22'd4096, 10'd0, 1'b1, 10'd5, 10'd4);
    step();
    cmd_valid = 1'b0;
    set_exp(0, 10'd5, 10'd256); set_exp(1, 10'd6, 10'd257);
    set_exp(2, 10'd7, 10'd258); set_exp(3, 10'd8, 10'd259);
    check_pulse(4);

    // Phase continuity: len-0 with junk fcw/phase_reset must leave acc running
    set_cmd(22'h200000, 10'd0, 1'b1, 10'd3, 10'd0);
    step();
    set_cmd(22'd4096, 10'd0, 1'b0, 10'd100, 10'd3);
    step();
    cmd_valid = 1'b0;
    set_exp(0, 10'd100, 10'd263); set_exp(1, 10'd101, 10'd264);
    set_exp(2, 10'd102, 10'd265);
    check_pulse(3);

    // Back-to-back with valid held
    set_cmd(22'd4096, 10'd0, 1'b1, 10'd10, 10'd3);
    step();
    set_cmd(22'd4096, 10'd0, 1'b0, 10'd20, 10'd3);
    check_eq("b2b_rd_addr0", env_rd_addr, 10);
    check_eq("b2b_ready0", cmd_ready, 0);
    step();
    check_eq("b2b_rd_addr1", env_rd_addr, 11);
    check_eq("b2b_mv1", mod_valid, 1);
    check_eq("b2b_ph1", mod_nco_phase, 256);
    check_eq("b2b_ready1", cmd_ready, 0);
    step();
    check_eq("b2b_rd_addr2", env_rd_addr, 12);
    check_eq("b2b_mv2", mod_valid, 1);
    check_eq("b2b_ph2", mod_nco_phase, 257);
    check_eq("b2b_ready2", cmd_ready, 1);
    check_eq("b2b_done2", done, 0);
    step();
    cmd_valid = 1'b0;
    check_eq("b2b_mv3", mod_valid, 1);
    check_eq("b2b_ph3", mod_nco_phase, 258);
    check_eq("b2b_done3", done, 1);
    set_exp(0, 10'd20, 10'd259); set_exp(1, 10'd21, 10'd260);
    set_exp(2, 10'd22, 10'd261);
    check_pulse(3);

    // Address wrap across the top of memory
    set_cmd(22'd4096, 10'd0, 1'b1, 10'd1022, 10'd4);
    step();
    cmd_valid = 1'b0;
    set_exp(0, 10'd1022, 10'd256); set_exp(1, 10'd1023, 10'd257);
    set_exp(2, 10'd0, 10'd258);    set_exp(3, 10'd1, 10'd259);
    check_pulse(4);

    // Two consecutive len-0 commands bring the frame back to 0, then fcw = 2^21
    set_cmd(22'd0, 10'd384, 1'b0, 10'd0, 10'd0);
    step();
    check_eq("vz2_ready", cmd_ready, 1);
    check_eq("vz2_busy", busy, 0);
    step();
    check_eq("vz3_ready", cmd_ready, 1);
    check_eq("vz3_busy", busy, 0);
    set_cmd(22'h200000, 10'd0, 1'b1, 10'd0, 10'd4);
    step();
    cmd_valid = 1'b0;
    set_exp(0, 10'd0, 10'd0); set_exp(1, 10'd1, 10'd512);
    set_exp(2, 10'd2, 10'd0); set_exp(3, 10'd3, 10'd512);
    check_pulse(4);

    // Reset mid-pulse, then reset dominating an accept
    set_cmd(22'd0, 10'd100, 1'b0, 10'd0, 10'd0);
    step();
    set_cmd(22'd4096, 10'd0, 1'b1, 10'd50, 10'd10);
    step();
    cmd_valid = 1'b0;
    check_eq("mid_rd_addr0", env_rd_addr, 50);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("mid_mv", mod_valid, 1);
      check_eq("mid_phase", mod_nco_phase, 32'(100 + k - 1));
      check_eq("mid_rd_addr", env_rd_addr, 32'(50 + k));
    end
    rst = 1'b1;
    set_cmd(22'd4096, 10'd0, 1'b1, 10'd60, 10'd5);
    step();
    check_eq("rstm_mv", mod_valid, 0);
    check_eq("rstm_busy", busy, 0);
    check_eq("rstm_ready", cmd_ready, 1);
    check_eq("rstm_rd_en", env_rd_en, 0);
    check_eq("rstm_done", done, 0);
    step();
    check_eq("rstp_busy", busy, 0);
    check_eq("rstp_rd_en", env_rd_en, 0);
    rst = 1'b0;
    set_cmd(22'd4096, 10'd0, 1'b0, 10'd0, 10'd2);
    step();
    cmd_valid = 1'b0;
    set_exp(0, 10'd0, 10'd0); set_exp(1, 10'd1, 10'd1);
    check_pulse(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
